// File: rtl/scan_pkg.sv
// Shared types, sizes and the skip-mask channel search for the 4-bit scan sequencer.
// The search function is only referenced when SCAN_SKIP_EN is defined.
package scan_pkg;

   localparam int ADDR_W = 4;
   localparam int NUM_CH = 16;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_BLANK = 2'd1,
      ST_DRIVE = 2'd2,
      ST_DONE  = 2'd3
   } scan_state_t;

   // Lowest unmasked channel at or above 'from'; MSB of the result flags that one exists.
   function automatic logic [ADDR_W:0] next_channel(input logic [NUM_CH-1:0] mask,
                                                    input logic [ADDR_W:0]   from);
      logic [ADDR_W:0] res;
      res = '0;
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         if (!mask[i] && (i >= int'(from))) begin
            res = {1'b1, ADDR_W'(i)};
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/scan_sequencer_4b_dwell_timer.sv
// Loadable down-counter shared by the blanking and dwell phases of the scan sequencer.
// Holds at zero once expired; load has priority over counting.
module dwell_timer #(
   parameter int W = 20
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic         zero
);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = load_val;
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign zero = (cnt_q == '0);

endmodule

// File: rtl/scan_sequencer_4b.sv
// Channel scanner driving address and active-low enable of a 4-to-16 decoder.
// Optional feature macro SCAN_SKIP_EN adds a per-channel skip_mask input.
module scan_sequencer_4b
   import scan_pkg::*;
#(
   parameter int DWELL_CYCLES = 1000,
   parameter int BLANK_CYCLES = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              stop,
   input  logic              continuous,
`ifdef SCAN_SKIP_EN
   input  logic [NUM_CH-1:0] skip_mask,
`endif
   output logic [ADDR_W-1:0] addr,
   output logic              en_n,
   output logic              busy,
   output logic              step,
   output logic              done
);

   if (DWELL_CYCLES < 1 || DWELL_CYCLES > (1 << 20)) begin : g_bad_dwell
      $error("scan_sequencer_4b: DWELL_CYCLES must be in 1..2^20");
   end
   if (BLANK_CYCLES < 1 || BLANK_CYCLES > 255) begin : g_bad_blank
      $error("scan_sequencer_4b: BLANK_CYCLES must be in 1..255");
   end

   localparam int TIMER_W = 20;
   localparam logic [TIMER_W-1:0] DWELL_LOAD = TIMER_W'(DWELL_CYCLES - 1);
   localparam logic [TIMER_W-1:0] BLANK_LOAD = TIMER_W'(BLANK_CYCLES - 1);
   localparam logic [ADDR_W-1:0]  LAST_CH    = ADDR_W'(NUM_CH - 1);

   scan_state_t       state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              en_n_q, en_n_d;
   logic              busy_q, busy_d;
   logic              step_q, step_d;
   logic              done_q, done_d;

   logic               tmr_load;
   logic [TIMER_W-1:0] tmr_val;
   logic               tmr_zero;

`ifdef SCAN_SKIP_EN
   logic [ADDR_W:0] first_ch;
   logic [ADDR_W:0] after_ch;

   assign first_ch = next_channel(skip_mask, '0);
   assign after_ch = next_channel(skip_mask, {1'b0, addr_q} + 5'd1);
`endif

   dwell_timer #(
      .W (TIMER_W)
   ) u_timer (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (tmr_load),
      .load_val (tmr_val),
      .zero     (tmr_zero)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         addr_q  <= '0;
         en_n_q  <= 1'b1;
         busy_q  <= 1'b0;
         step_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         en_n_q  <= en_n_d;
         busy_q  <= busy_d;
         step_q  <= step_d;
         done_q  <= done_d;
      end
   end

   // Address moves only together with a state change into BLANK or IDLE.
   always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      tmr_load = 1'b0;
      tmr_val  = BLANK_LOAD;
      unique case (state_q)
         ST_IDLE: begin
            if (start && !stop) begin
`ifdef SCAN_SKIP_EN
               if (first_ch[ADDR_W]) begin
                  state_d  = ST_BLANK;
                  addr_d   = first_ch[ADDR_W-1:0];
                  tmr_load = 1'b1;
               end else begin
                  state_d = ST_DONE;
               end
`else
               state_d  = ST_BLANK;
               addr_d   = '0;
               tmr_load = 1'b1;
`endif
            end
         end
         ST_BLANK: begin
            if (stop) begin
               state_d = ST_IDLE;
               addr_d  = '0;
            end else if (tmr_zero) begin
               state_d  = ST_DRIVE;
               tmr_load = 1'b1;
               tmr_val  = DWELL_LOAD;
            end
         end
         ST_DRIVE: begin
            if (stop) begin
               state_d = ST_IDLE;
               addr_d  = '0;
            end else if (tmr_zero) begin
`ifdef SCAN_SKIP_EN
               if (after_ch[ADDR_W]) begin
                  state_d  = ST_BLANK;
                  addr_d   = after_ch[ADDR_W-1:0];
                  tmr_load = 1'b1;
               end else if (continuous && first_ch[ADDR_W]) begin
                  state_d  = ST_BLANK;
                  addr_d   = first_ch[ADDR_W-1:0];
                  tmr_load = 1'b1;
               end else begin
                  state_d = ST_DONE;
               end
`else
               if (addr_q != LAST_CH) begin
                  state_d  = ST_BLANK;
                  addr_d   = addr_q + 1'b1;
                  tmr_load = 1'b1;
               end else if (continuous) begin
                  state_d  = ST_BLANK;
                  addr_d   = '0;
                  tmr_load = 1'b1;
               end else begin
                  state_d = ST_DONE;
               end
`endif
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
            addr_d  = '0;
         end
         default: begin
            state_d = ST_IDLE;
            addr_d  = '0;
         end
      endcase
   end

   // Outputs are decoded from the next state so every port comes straight off a flop.
   always_comb begin
      en_n_d = (state_d != ST_DRIVE);
      busy_d = (state_d == ST_BLANK) || (state_d == ST_DRIVE);
      step_d = (state_d == ST_DRIVE) && (state_q != ST_DRIVE);
      done_d = (state_d == ST_DONE);
   end

   assign addr = addr_q;
   assign en_n = en_n_q;
   assign busy = busy_q;
   assign step = step_q;
   assign done = done_q;

endmodule

// File: tb/tb_scan_sequencer_4b.sv
// Self-checking bench for scan_sequencer_4b: position-based reference model plus directed scenarios.
// Skip-mask scenarios are included when SCAN_SKIP_EN is defined.
module tb_scan_sequencer_4b;

   localparam int DW = 3;
   localparam int BL = 1;
   localparam int P  = DW + BL;
   localparam int L  = 16 * P;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic       stop = 1'b0;
   logic       continuous = 1'b0;
`ifdef SCAN_SKIP_EN
   logic [15:0] skip_mask = '0;
`endif
   logic [3:0] addr;
   logic       en_n;
   logic       busy;
   logic       step;
   logic       done;

   int checks = 0;
   int failures = 0;
   bit chk_en = 1'b0;

   always #5 clk = ~clk;

   scan_sequencer_4b #(
      .DWELL_CYCLES (DW),
      .BLANK_CYCLES (BL)
   ) dut (
`ifdef SCAN_SKIP_EN
      .skip_mask  (skip_mask),
`endif
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .stop       (stop),
      .continuous (continuous),
      .addr       (addr),
      .en_n       (en_n),
      .busy       (busy),
      .step       (step),
      .done       (done)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: a scan is just a position counter within a 16*P-cycle pass.
   bit m_active;
   bit m_done;
   int m_pos;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_active = 1'b0;
         m_done   = 1'b0;
         m_pos    = 0;
      end else if (m_done) begin
         m_done = 1'b0;
      end else if (m_active) begin
         if (stop) begin
            m_active = 1'b0;
         end else if (m_pos == L - 1) begin
            if (continuous) begin
               m_pos = 0;
            end else begin
               m_active = 1'b0;
               m_done   = 1'b1;
            end
         end else begin
            m_pos++;
         end
      end else if (start && !stop) begin
         m_active = 1'b1;
         m_pos    = 0;
      end
   end

   always @(negedge clk) begin
      if (rst_n && chk_en) begin
         int exp_addr;
         bit exp_drive;
         exp_addr  = m_done ? 15 : (m_active ? m_pos / P : 0);
         exp_drive = m_active && ((m_pos % P) >= BL);
         check("model_addr", 32'(addr), 32'(exp_addr));
         check("model_en_n", 32'(en_n), 32'(!exp_drive));
         check("model_busy", 32'(busy), 32'(m_active));
         check("model_step", 32'(step), 32'(m_active && ((m_pos % P) == BL)));
         check("model_done", 32'(done), 32'(m_done));
      end
   end

   // One start pulse, then observe until done; optional extra start at cycle extra_at.
   task automatic run_pass(input int extra_at, output int k, output int nsteps,
                           output int enlow, output int seqerr, output bit got);
      k = 0; nsteps = 0; enlow = 0; seqerr = 0; got = 1'b0;
      @(negedge clk) start = 1'b1;
      @(posedge clk) k = 1;
      @(negedge clk) start = 1'b0;
      for (int i = 0; i < 400; i++) begin
         if (step) begin
            if (int'(addr) != (nsteps % 16)) seqerr++;
            nsteps++;
         end
         if (!en_n) enlow++;
         if (done) begin
            got = 1'b1;
            break;
         end
         start = (k == extra_at);
         @(posedge clk) k++;
         @(negedge clk) start = 1'b0;
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int k, ns, el, se, dones, wraps, prev;
      bit got, found;

      repeat (3) @(negedge clk);
      check("rst_addr", 32'(addr), 0);
      check("rst_en_n", 32'(en_n), 1);
      check("rst_busy", 32'(busy), 0);
      check("rst_step", 32'(step), 0);
      check("rst_done", 32'(done), 0);
      rst_n  = 1'b1;
      chk_en = 1'b1;
      repeat (2) @(negedge clk);

      // Single pass
      continuous = 1'b0;
      run_pass(-1, k, ns, el, se, got);
      check("pass_done_seen", 32'(got), 1);
      check("pass_len", 32'(k), 65);
      check("pass_steps", 32'(ns), 16);
      check("pass_en_low", 32'(el), 48);
      check("pass_addr_seq_err", 32'(se), 0);
      repeat (3) @(negedge clk);

      // Continuous: two full passes
      continuous = 1'b1;
      dones = 0; wraps = 0; ns = 0;
      @(negedge clk) start = 1'b1;
      @(posedge clk);
      @(negedge clk) start = 1'b0;
      prev = int'(addr);
      for (int i = 1; i <= 2 * L; i++) begin
         if (done) dones++;
         if (step) ns++;
         if (prev == 15 && addr == 4'd0 && busy) wraps++;
         prev = int'(addr);
         if (i < 2 * L) @(negedge clk);
      end
      check("cont_dones", 32'(dones), 0);
      check("cont_steps", 32'(ns), 32);
      check("cont_wraps", 32'(wraps), 1);
      continuous = 1'b0;
      stop = 1'b1;
      @(negedge clk) stop = 1'b0;
      check("cont_stop_busy", 32'(busy), 0);
      repeat (2) @(negedge clk);

      // Stop on the second DRIVE cycle of channel 5
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      found = 1'b0;
      for (int i = 0; i < 300; i++) begin
         if (addr == 4'd5 && step) begin
            found = 1'b1;
            break;
         end
         @(negedge clk);
      end
      check("stop_ch5_reached", 32'(found), 1);
      @(negedge clk) stop = 1'b1;
      @(negedge clk) stop = 1'b0;
      check("stop_en_n", 32'(en_n), 1);
      check("stop_addr", 32'(addr), 0);
      check("stop_busy", 32'(busy), 0);
      check("stop_done", 32'(done), 0);
      repeat (4) @(negedge clk);

      // Start and stop together in IDLE
      start = 1'b1; stop = 1'b1;
      @(negedge clk) begin start = 1'b0; stop = 1'b0; end
      check("start_stop_busy", 32'(busy), 0);
      repeat (2) @(negedge clk);

      // Start during DRIVE of channel 0 is ignored
      run_pass(3, k, ns, el, se, got);
      check("restart_done_seen", 32'(got), 1);
      check("restart_len", 32'(k), 65);
      check("restart_steps", 32'(ns), 16);
      repeat (3) @(negedge clk);

      // Asynchronous reset in DRIVE of channel 9
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      found = 1'b0;
      for (int i = 0; i < 300; i++) begin
         if (addr == 4'd9 && !en_n) begin
            found = 1'b1;
            break;
         end
         @(negedge clk);
      end
      check("arst_ch9_reached", 32'(found), 1);
      #2 rst_n = 1'b0;
      #1;
      check("arst_en_n", 32'(en_n), 1);
      check("arst_addr", 32'(addr), 0);
      check("arst_busy", 32'(busy), 0);
      check("arst_step", 32'(step), 0);
      @(negedge clk) rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // Randomized traffic against the model
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         start = ($urandom_range(7) == 0);
         stop  = ($urandom_range(255) == 0);
         if ($urandom_range(99) == 0) continuous = ~continuous;
      end
      @(negedge clk) begin start = 1'b0; stop = 1'b1; continuous = 1'b0; end
      @(negedge clk) stop = 1'b0;
      repeat (2) @(negedge clk);

`ifdef SCAN_SKIP_EN
      chk_en = 1'b0;
      skip_mask = 16'hFFF0;
      run_pass(-1, k, ns, el, se, got);
      check("skip4_done_seen", 32'(got), 1);
      check("skip4_len", 32'(k), 1 + 4 * P);
      check("skip4_steps", 32'(ns), 4);
      check("skip4_addr_seq_err", 32'(se), 0);
      repeat (3) @(negedge clk);
      skip_mask = 16'hFFFF;
      run_pass(-1, k, ns, el, se, got);
      check("skipall_done_seen", 32'(got), 1);
      check("skipall_len", 32'(k), 1);
      check("skipall_steps", 32'(ns), 0);
      repeat (3) @(negedge clk);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
